// File: rtl/miss_controller.sv
// Cache miss controller: optionally writes back a dirty victim, fetches the
// missing word from backing memory, then presents it to the cache for one
// cycle. Keeps saturating counts of serviced misses and writebacks.
//
// Memory handshake: memRead/memWrite together with memAddr/memDataOut are a
// request that stays asserted and stable until memReady=1 is sampled on a
// rising clk edge; that edge completes the request. memReady is ignored
// whenever no request is outstanding.
module miss_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  missReq,
    input  logic [ADDR_WIDTH-1:0] missAddr,
    input  logic                  victimDirty,
    input  logic [ADDR_WIDTH-1:0] victimAddr,
    input  logic [DATA_WIDTH-1:0] victimData,
    output logic                  busy,
    output logic                  fillValid,
    output logic [ADDR_WIDTH-1:0] fillAddr,
    output logic [DATA_WIDTH-1:0] fillData,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memDataOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    input  logic                  memReady,
    output logic [CNT_WIDTH-1:0]  missCount,
    output logic [CNT_WIDTH-1:0]  wbCount,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic                  wb_done;
    logic                  fetch_done;

    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic                  victim_dirty_q;
    logic [ADDR_WIDTH-1:0] victim_addr_q;
    logic [DATA_WIDTH-1:0] victim_data_q;
    logic [ADDR_WIDTH-1:0] fill_addr_q;
    logic [DATA_WIDTH-1:0] fill_data_q;
    logic [CNT_WIDTH-1:0]  miss_cnt_q;
    logic [CNT_WIDTH-1:0]  wb_cnt_q;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all handshake outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        busy       = (state_q != IDLE);
        fillValid  = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddr    = '0;
        memDataOut = '0;
        accept     = 1'b0;
        wb_done    = 1'b0;
        fetch_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (missReq) begin
                    accept  = 1'b1;
                    state_d = victimDirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                memWrite   = 1'b1;
                memAddr    = victim_addr_q;
                memDataOut = victim_data_q;
                if (memReady) begin
                    wb_done = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                memRead = 1'b1;
                memAddr = miss_addr_q;
                if (memReady) begin
                    fetch_done = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                fillValid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on the accepting edge so the cache may move on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_addr_q    <= '0;
            victim_dirty_q <= 1'b0;
            victim_addr_q  <= '0;
            victim_data_q  <= '0;
        end else if (accept) begin
            miss_addr_q    <= missAddr;
            victim_dirty_q <= victimDirty;
            victim_addr_q  <= victimAddr;
            victim_data_q  <= victimData;
        end
    end

    // Fill word and address load when the fetch completes and then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else if (fetch_done) begin
            fill_addr_q <= miss_addr_q;
            fill_data_q <= memDataIn;
        end
    end

    // Saturating statistics: one miss per FILL cycle, one writeback per
    // completed dirty-victim write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == FILL && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
            if (wb_done && victim_dirty_q && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign fillAddr  = fill_addr_q;
    assign fillData  = fill_data_q;
    assign missCount = miss_cnt_q;
    assign wbCount   = wb_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_miss_controller.sv
// Bench for miss_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model. A second instance with 2-bit counters covers saturation.
module tb_miss_controller;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          missReq = 1'b0;
    logic [AW-1:0] missAddr = '0;
    logic          victimDirty = 1'b0;
    logic [AW-1:0] victimAddr = '0;
    logic [DW-1:0] victimData = '0;
    logic [DW-1:0] memDataIn = '0;
    logic          memReady = 1'b0;

    logic          busy, fillValid, memRead, memWrite;
    logic [AW-1:0] fillAddr, memAddr;
    logic [DW-1:0] fillData, memDataOut;
    logic [CW-1:0] missCount, wbCount;
    logic [1:0]    state_dbg;

    logic          s_busy, s_fillValid, s_memRead, s_memWrite;
    logic [AW-1:0] s_fillAddr, s_memAddr;
    logic [DW-1:0] s_fillData, s_memDataOut;
    logic [1:0]    s_missCount, s_wbCount;
    logic [1:0]    s_state_dbg;

    miss_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .missReq(missReq), .missAddr(missAddr),
        .victimDirty(victimDirty), .victimAddr(victimAddr), .victimData(victimData),
        .busy(busy), .fillValid(fillValid), .fillAddr(fillAddr), .fillData(fillData),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
        .memDataOut(memDataOut), .memDataIn(memDataIn), .memReady(memReady),
        .missCount(missCount), .wbCount(wbCount), .state_dbg(state_dbg)
    );

    miss_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .missReq(missReq), .missAddr(missAddr),
        .victimDirty(victimDirty), .victimAddr(victimAddr), .victimData(victimData),
        .busy(s_busy), .fillValid(s_fillValid), .fillAddr(s_fillAddr), .fillData(s_fillData),
        .memRead(s_memRead), .memWrite(s_memWrite), .memAddr(s_memAddr),
        .memDataOut(s_memDataOut), .memDataIn(memDataIn), .memReady(memReady),
        .missCount(s_missCount), .wbCount(s_wbCount), .state_dbg(s_state_dbg)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding transaction: whether a writeback is still owed, whether
    // the fetch has returned (meaning the fill strobe is due this cycle).
    logic          m_busy = 1'b0;
    logic          m_wb_owed = 1'b0;
    logic          m_fetched = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_vaddr = '0;
    logic [DW-1:0] m_vdata = '0;
    logic [AW-1:0] m_fill_addr = '0;
    logic [DW-1:0] m_fill_data = '0;
    int            m_miss = 0;
    int            m_wb = 0;
    logic [AW+DW-1:0] exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy      <= 1'b0;
            m_wb_owed   <= 1'b0;
            m_fetched   <= 1'b0;
            m_addr      <= '0;
            m_vaddr     <= '0;
            m_vdata     <= '0;
            m_fill_addr <= '0;
            m_fill_data <= '0;
            m_miss      <= 0;
            m_wb        <= 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (missReq) begin
                m_busy    <= 1'b1;
                m_wb_owed <= victimDirty;
                m_fetched <= 1'b0;
                m_addr    <= missAddr;
                m_vaddr   <= victimAddr;
                m_vdata   <= victimData;
            end
        end else if (m_wb_owed) begin
            if (memReady) begin
                m_wb_owed <= 1'b0;
                m_wb      <= m_wb + 1;
            end
        end else if (!m_fetched) begin
            if (memReady) begin
                m_fetched   <= 1'b1;
                m_fill_addr <= m_addr;
                m_fill_data <= memDataIn;
                exp_q.push_back({m_addr, memDataIn});
            end
        end else begin
            m_busy    <= 1'b0;
            m_fetched <= 1'b0;
            m_miss    <= m_miss + 1;
        end
    end

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_wr, exp_rd, exp_fv;
        logic [AW+DW-1:0] fe;
        if (!reset) begin
            exp_wr = m_busy && m_wb_owed;
            exp_rd = m_busy && !m_wb_owed && !m_fetched;
            exp_fv = m_busy && !m_wb_owed && m_fetched;
            chk("m_busy", busy, m_busy);
            chk("m_memWrite", memWrite, exp_wr);
            chk("m_memRead", memRead, exp_rd);
            chk("m_fillValid", fillValid, exp_fv);
            chk("m_rw_excl", memRead & memWrite, 1'b0);
            if (exp_wr) begin
                chk("m_wr_addr", memAddr, m_vaddr);
                chk("m_wr_data", memDataOut, m_vdata);
            end
            if (exp_rd) chk("m_rd_addr", memAddr, m_addr);
            chk("m_fillAddr", fillAddr, m_fill_addr);
            chk("m_fillData", fillData, m_fill_data);
            chk("m_missCount", missCount, sat(m_miss, 65535));
            chk("m_wbCount", wbCount, sat(m_wb, 65535));
            chk("m_s_busy", s_busy, m_busy);
            chk("m_s_missCount", s_missCount, sat(m_miss, 3));
            chk("m_s_wbCount", s_wbCount, sat(m_wb, 3));
            if (fillValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_fill actual=0x%0h expected=none at %0t",
                             {fillAddr, fillData}, $time);
                end else begin
                    fe = exp_q.pop_front();
                    chk("sb_fill", {8'h00, fillAddr, fillData}, {8'h00, fe});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [AW-1:0] a, input logic d,
                           input logic [AW-1:0] va, input logic [DW-1:0] vd);
        missReq     = 1'b1;
        missAddr    = a;
        victimDirty = d;
        victimAddr  = va;
        victimData  = vd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // after reset
        chk("rst_busy", busy, 1'b0);
        chk("rst_fillValid", fillValid, 1'b0);
        chk("rst_memRead", memRead, 1'b0);
        chk("rst_memWrite", memWrite, 1'b0);
        chk("rst_fillAddr", fillAddr, 8'h00);
        chk("rst_fillData", fillData, 16'h0000);
        chk("rst_missCount", missCount, 16'd0);
        chk("rst_wbCount", wbCount, 16'd0);

        // clean miss
        set_req(8'h12, 1'b0, 8'h00, 16'h0000);
        memReady = 1'b1;
        memDataIn = 16'hBEEF;
        tick();
        missReq = 1'b0;
        chk("clean_memRead", memRead, 1'b1);
        chk("clean_memAddr", memAddr, 8'h12);
        chk("clean_memWrite", memWrite, 1'b0);
        tick();
        chk("clean_fillValid", fillValid, 1'b1);
        chk("clean_fillAddr", fillAddr, 8'h12);
        chk("clean_fillData", fillData, 16'hBEEF);
        tick();
        chk("clean_fillValid_off", fillValid, 1'b0);
        chk("clean_missCount", missCount, 16'd1);
        chk("clean_wbCount", wbCount, 16'd0);

        // dirty miss, memory slow in both phases
        memReady = 1'b0;
        set_req(8'h34, 1'b1, 8'h74, 16'hA5A5);
        tick();
        set_req(8'h00, 1'b0, 8'h00, 16'h0000);
        missReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("dirty_memWrite", memWrite, 1'b1);
            chk("dirty_wr_memRead", memRead, 1'b0);
            chk("dirty_wr_addr", memAddr, 8'h74);
            chk("dirty_wr_data", memDataOut, 16'hA5A5);
            memReady = (k == 3);
            tick();
        end
        memReady = 1'b0;
        chk("dirty_wbCount", wbCount, 16'd1);
        for (int k = 0; k < 4; k++) begin
            chk("dirty_memRead", memRead, 1'b1);
            chk("dirty_rd_memWrite", memWrite, 1'b0);
            chk("dirty_rd_addr", memAddr, 8'h34);
            memReady = (k == 3);
            memDataIn = (k == 3) ? 16'hC3D2 : 16'h0BAD;
            tick();
        end
        memReady = 1'b0;
        chk("dirty_fillValid", fillValid, 1'b1);
        chk("dirty_fillAddr", fillAddr, 8'h34);
        chk("dirty_fillData", fillData, 16'hC3D2);
        tick();
        chk("dirty_fillValid_off", fillValid, 1'b0);
        chk("dirty_missCount", missCount, 16'd2);

        // requests while busy are ignored
        set_req(8'h40, 1'b0, 8'h00, 16'h0000);
        tick();
        missAddr = 8'h55;
        tick();
        tick();
        missReq = 1'b0;
        memReady = 1'b1;
        memDataIn = 16'h7777;
        tick();
        memReady = 1'b0;
        chk("busyreq_fillAddr", fillAddr, 8'h40);
        tick();
        chk("busyreq_busy", busy, 1'b0);
        chk("busyreq_missCount", missCount, 16'd3);

        // reset during fetch
        set_req(8'h66, 1'b0, 8'h00, 16'h0000);
        tick();
        missReq = 1'b0;
        chk("rstmid_memRead_before", memRead, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("rstmid_memRead", memRead, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_fillValid", fillValid, 1'b0);
        chk("rstmid_missCount", missCount, 16'd0);
        chk("rstmid_wbCount", wbCount, 16'd0);
        chk("rstmid_fillAddr", fillAddr, 8'h00);
        memReady = 1'b1;
        tick();
        chk("rstmid_fillValid_hold", fillValid, 1'b0);
        reset = 1'b0;
        memReady = 1'b0;
        tick();
        chk("rstmid_after_busy", busy, 1'b0);
        chk("rstmid_after_missCount", missCount, 16'd0);

        // back-to-back clean misses
        memReady = 1'b1;
        memDataIn = 16'h1111;
        set_req(8'h01, 1'b0, 8'h00, 16'h0000);
        tick();
        missReq = 1'b0;
        tick();
        chk("b2b_fill1", fillValid, 1'b1);
        chk("b2b_fill1_addr", fillAddr, 8'h01);
        set_req(8'h02, 1'b0, 8'h00, 16'h0000);
        memDataIn = 16'h2222;
        tick();
        chk("b2b_idle", busy, 1'b0);
        tick();
        missReq = 1'b0;
        chk("b2b_rd2_addr", memAddr, 8'h02);
        tick();
        chk("b2b_fill2", fillValid, 1'b1);
        chk("b2b_fill2_addr", fillAddr, 8'h02);
        chk("b2b_fill2_data", fillData, 16'h2222);
        tick();
        chk("b2b_missCount", missCount, 16'd2);

        // saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            set_req(AW'(8'h80 + i), 1'b0, 8'h00, 16'h0000);
            tick();
            missReq = 1'b0;
            tick();
            tick();
        end
        chk("sat_missCount_wide", missCount, 16'd7);
        chk("sat_missCount_small", s_missCount, 2'd3);
        chk("sat_wbCount_small", s_wbCount, 2'd0);

        // randomized traffic with occasional asynchronous reset
        for (int cyc = 0; cyc < 2000; cyc++) begin
            missReq     = ($urandom_range(0, 99) < 50);
            missAddr    = AW'($urandom);
            victimDirty = 1'($urandom_range(0, 1));
            victimAddr  = AW'($urandom);
            victimData  = DW'($urandom);
            memDataIn   = DW'($urandom);
            memReady    = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 399) == 0) begin
                #3 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        missReq = 1'b0;
        memReady = 1'b1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/miss_controller.md
MISS_CONTROLLER -- requirements
Module: miss_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning cache/memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning data word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the statistics counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port missReq, input, 1, cache reports a miss needing service.
REQ-007 SHALL have port missAddr, input, ADDR_WIDTH, address of the word to fetch.
REQ-008 SHALL have port victimDirty, input, 1, the evicted way holds modified data.
REQ-009 SHALL have port victimAddr, input, ADDR_WIDTH, address of the evicted word.
REQ-010 SHALL have port victimData, input, DATA_WIDTH, evicted word contents.
REQ-011 SHALL have port busy, output, 1, controller not in IDLE.
REQ-012 SHALL have port fillValid, output, 1, one-cycle strobe: fill word ready for the cache.
REQ-013 SHALL have port fillAddr, output, ADDR_WIDTH, address of the fill word.
REQ-014 SHALL have port fillData, output, DATA_WIDTH, fill word.
REQ-015 SHALL have port memRead, output, 1, read request to backing memory.
REQ-016 SHALL have port memWrite, output, 1, write request to backing memory.
REQ-017 SHALL have port memAddr, output, ADDR_WIDTH, memory address.
REQ-018 SHALL have port memDataOut, output, DATA_WIDTH, write data to memory.
REQ-019 SHALL have port memDataIn, input, DATA_WIDTH, read data from memory.
REQ-020 SHALL have port memReady, input, 1, memory completes the current request this cycle.
REQ-021 SHALL have ports missCount and wbCount, output, CNT_WIDTH, serviced-miss and writeback totals.

Function
REQ-022 SHALL implement FSM states IDLE, WRITEBACK, FETCH, FILL; busy = (state != IDLE).
REQ-023 SHALL accept a request only in IDLE with missReq=1, registering missAddr, victimDirty, victimAddr, victimData on that edge; missReq while busy is ignored.
REQ-024 SHALL transition IDLE->WRITEBACK on accept when victimDirty=1, else IDLE->FETCH.
REQ-025 SHALL in WRITEBACK drive memWrite=1, memAddr=registered victimAddr, memDataOut=registered victimData, held stable until memReady=1 is sampled, then go to FETCH.
REQ-026 SHALL in FETCH drive memRead=1, memAddr=registered missAddr, held until memReady=1 is sampled; on that edge capture memDataIn into fillData and go to FILL.
REQ-027 SHALL in FILL drive fillValid=1 for exactly one cycle with fillAddr=registered missAddr, then return to IDLE.
REQ-028 SHALL never assert memRead and memWrite in the same cycle; both 0 in IDLE and FILL.
REQ-029 SHALL ignore memReady in IDLE and FILL.
REQ-030 SHALL keep fillData/fillAddr holding last fill values after FILL until the next fill.
REQ-031 SHALL increment missCount on each FILL cycle and wbCount on each WRITEBACK exit; both saturate at all-ones.
REQ-032 SHALL yield minimum latency accept-edge to fillValid of 2 cycles (clean, memReady already high) and 3 cycles (dirty).
REQ-033 SHALL allow a new request to be accepted on the cycle after FILL (back-to-back).

Reset
REQ-034 SHALL on reset=1 immediately (asynchronously) force state IDLE and busy, fillValid, memRead, memWrite to 0.
REQ-035 SHALL on reset clear fillAddr, fillData, memAddr, memDataOut, missCount, wbCount and all registered request fields to 0.
REQ-036 SHALL on reset mid-transaction abandon it with no fill strobe and no counter update.

Verification
REQ-037 Clean miss: missReq=1, missAddr=0x12, victimDirty=0, memReady=1 in FETCH with memDataIn=0xBEEF -> memRead with memAddr=0x12, then fillValid=1, fillAddr=0x12, fillData=0xBEEF, missCount=1, wbCount=0.
REQ-038 Dirty miss: missAddr=0x34, victimDirty=1, victimAddr=0x74, victimData=0xA5A5, memReady held low 3 cycles each phase -> memWrite (0x74, 0xA5A5) held 4 cycles, then memRead 0x34 held 4 cycles, fillValid once, wbCount=1.
REQ-039 missReq pulsed with new address while busy -> ignored; only the first address is filled, missCount increments once.
REQ-040 reset asserted during FETCH -> memRead drops in same cycle, no fillValid, counters 0.
REQ-041 Two back-to-back clean misses (0x01, 0x02) with memReady=1 -> two fillValid pulses, missCount=2.
REQ-042 Counter saturation: preload via CNT_WIDTH=2, run 5 misses -> missCount stays 3.
